// File: rtl/ehgu_sr_mem_prog_pkg.sv
// ehgu_sr_pkg: shared constants and helpers for the programmable memory
// delay line.
//   min_addr_width(depth) : smallest address width that covers depth words
//   max_delay(depth)      : largest legal delay for a RAM of depth words
//   DEF_MEM_DEPTH         : default RAM depth
//   MAX_DELAY             : largest legal delay at the default depth
package ehgu_sr_pkg;

    localparam int unsigned DEF_MEM_DEPTH = 128;

    function automatic int unsigned min_addr_width(input int unsigned depth);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < depth) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    function automatic int unsigned max_delay(input int unsigned depth);
        return depth - 1;
    endfunction

    localparam int unsigned MAX_DELAY = max_delay(DEF_MEM_DEPTH);

endpackage

// File: rtl/ehgu_sr_mem_prog_if.sv
// ehgu_sr_mem_prog_if: sample stream and configuration bus of the delay line.
//   en, data_in      : sample strobe and sample
//   clr              : synchronous flush
//   cfg_load         : load cfg_delay as the new delay (also flushes)
//   cfg_delay        : requested delay in en strobes
//   data_out         : delayed sample, 0 until the line is primed
//   valid_out        : data_out holds a real delayed sample
//   delay_q          : currently active delay
// master drives samples/configuration, slave is the delay line.
interface ehgu_sr_mem_prog_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned AWIDTH = 7
);
    logic              en;
    logic [WIDTH-1:0]  data_in;
    logic              clr;
    logic              cfg_load;
    logic [AWIDTH-1:0] cfg_delay;
    logic [WIDTH-1:0]  data_out;
    logic              valid_out;
    logic [AWIDTH-1:0] delay_q;

    modport master (
        output en, data_in, clr, cfg_load, cfg_delay,
        input  data_out, valid_out, delay_q
    );

    modport slave (
        input  en, data_in, clr, cfg_load, cfg_delay,
        output data_out, valid_out, delay_q
    );
endinterface

// File: rtl/ehgu_sr_mem_prog_ram.sv
// ehgu_ram_dual_port: simple dual-port RAM, one write port and one
// registered read port.
//   wclk, wenable, waddr, wdata : write port
//   rclk, renable, raddr, rdata : read port, rdata updates when renable=1
// Contents and rdata are not reset.
module ehgu_ram_dual_port
    import ehgu_sr_pkg::*;
#(
    parameter int unsigned DEPTH  = 128,
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned AWIDTH = min_addr_width(DEPTH)
) (
    input  logic              wclk,
    input  logic              wenable,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              rclk,
    input  logic              renable,
    input  logic [AWIDTH-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge wclk) begin
        if (wenable) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge rclk) begin
        if (renable) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/ehgu_sr_mem_prog.sv
// ehgu_sr_mem_prog: run-time programmable delay line with RAM storage.
//   clk  : clock
//   rstn : asynchronous active-low reset
//   bus  : sample/config interface (slave side), see ehgu_sr_mem_prog_if
// Priority: rstn > cfg_load > clr > en. A flush (clr or cfg_load) drops any
// sample offered in the same cycle.
module ehgu_sr_mem_prog
    import ehgu_sr_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MEM_DEPTH = 128,
    parameter int unsigned DEF_DELAY = 20
) (
    input  logic                clk,
    input  logic                rstn,
    ehgu_sr_mem_prog_if.slave   bus
);
    localparam int unsigned     AWIDTH = min_addr_width(MEM_DEPTH);
    localparam logic [AWIDTH-1:0] DEF_D  = AWIDTH'(DEF_DELAY);
    localparam logic [AWIDTH-1:0] MAX_D  = AWIDTH'(max_delay(MEM_DEPTH));

    logic [AWIDTH-1:0] wptr;
    logic [AWIDTH-1:0] fill;
    logic [AWIDTH-1:0] delay_r;
    logic [AWIDTH-1:0] raddr;
    logic [AWIDTH-1:0] cfg_sat;
    logic              valid_r;
    logic [WIDTH-1:0]  byp_q;
    logic [WIDTH-1:0]  ram_q;
    logic              flush;
    logic              accept;

    assign flush  = bus.cfg_load | bus.clr;
    assign accept = bus.en & ~flush;

    always_comb begin
        cfg_sat = (bus.cfg_delay > MAX_D) ? MAX_D : bus.cfg_delay;
        // Reading D words behind the write pointer lands x[n-D] in the RAM
        // output register on the same edge that writes x[n]. D=0 uses the
        // bypass register, so point the read elsewhere to keep the ports apart.
        if (delay_r == '0) begin
            raddr = wptr + AWIDTH'(1);
        end else begin
            raddr = wptr - delay_r;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr    <= '0;
            fill    <= '0;
            delay_r <= DEF_D;
            valid_r <= 1'b0;
            byp_q   <= '0;
        end else if (bus.cfg_load) begin
            delay_r <= cfg_sat;
            wptr    <= '0;
            fill    <= '0;
            valid_r <= 1'b0;
        end else if (bus.clr) begin
            wptr    <= '0;
            fill    <= '0;
            valid_r <= 1'b0;
        end else if (bus.en) begin
            wptr    <= wptr + AWIDTH'(1);
            // fill == D means at least D samples are already stored, so the
            // sample being accepted now has its partner in the RAM.
            valid_r <= (fill == delay_r);
            if (fill != delay_r) begin
                fill <= fill + AWIDTH'(1);
            end
            byp_q   <= bus.data_in;
        end
    end

    ehgu_ram_dual_port #(
        .DEPTH  (MEM_DEPTH),
        .WIDTH  (WIDTH),
        .AWIDTH (AWIDTH)
    ) u_ram (
        .wclk    (clk),
        .wenable (accept),
        .waddr   (wptr),
        .wdata   (bus.data_in),
        .rclk    (clk),
        .renable (bus.en),
        .raddr   (raddr),
        .rdata   (ram_q)
    );

    // RAM output register is not reset or flushed; gating on valid keeps
    // stale contents hidden.
    assign bus.data_out  = valid_r ? ((delay_r == '0) ? byp_q : ram_q) : '0;
    assign bus.valid_out = valid_r;
    assign bus.delay_q   = delay_r;
endmodule

// File: tb/tb_ehgu_sr_mem_prog.sv
// tb_ehgu_sr_mem_prog: directed, table-driven bench for ehgu_sr_mem_prog.
module tb_ehgu_sr_mem_prog;
    import ehgu_sr_pkg::*;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned AWIDTH = 7;

    logic clk;
    logic rstn;
    int   checks;
    int   errors;

    ehgu_sr_mem_prog_if #(.WIDTH(WIDTH), .AWIDTH(AWIDTH)) bus ();

    ehgu_sr_mem_prog #(
        .WIDTH     (WIDTH),
        .MEM_DEPTH (128),
        .DEF_DELAY (20)
    ) u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              en;
        logic [WIDTH-1:0]  din;
        logic              clr;
        logic              cfg_load;
        logic [AWIDTH-1:0] cfg_delay;
        logic [WIDTH-1:0]  exp_data;
        logic              exp_valid;
        logic [AWIDTH-1:0] exp_delay;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [WIDTH-1:0] din,
                         input logic clr, input logic ld,
                         input logic [AWIDTH-1:0] d);
        bus.en        = en;
        bus.data_in   = din;
        bus.clr       = clr;
        bus.cfg_load  = ld;
        bus.cfg_delay = d;
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic en, input logic [WIDTH-1:0] din,
                        input logic clr, input logic ld,
                        input logic [AWIDTH-1:0] d);
        drive(en, din, clr, ld, d);
        @(posedge clk);
        #1;
        drive(1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic chk_out(input string name, input int exp_d, input int exp_v);
        chk({name, ".data"}, int'(bus.data_out), exp_d);
        chk({name, ".valid"}, int'(bus.valid_out), exp_v);
    endtask

    vec_t v;
    int   n;
    int   exp_d;
    int   exp_v;
    logic [WIDTH-1:0] ramp;

    initial begin
        checks = 0;
        errors = 0;
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.data", int'(bus.data_out), 0);
        chk("reset.valid", int'(bus.valid_out), 0);
        chk("reset.delay", int'(bus.delay_q), 20);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Table: 30 samples 1..30 through the default delay of 20, then a
        // reconfiguration to D=0 and two bypass samples.
        for (int k = 1; k <= 30; k++) begin
            v = '{en: 1'b1, din: 8'(k), clr: 1'b0, cfg_load: 1'b0, cfg_delay: '0,
                  exp_data: (k >= 21) ? 8'(k - 20) : 8'd0,
                  exp_valid: (k >= 21), exp_delay: 7'd20};
            vecs.push_back(v);
        end
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 7'd0, 8'd10, 1'b1, 7'd20});
        vecs.push_back('{1'b1, 8'hFF, 1'b0, 1'b1, 7'd0, 8'h00, 1'b0, 7'd0});
        vecs.push_back('{1'b1, 8'hA5, 1'b0, 1'b0, 7'd0, 8'hA5, 1'b1, 7'd0});
        vecs.push_back('{1'b1, 8'h5A, 1'b0, 1'b0, 7'd0, 8'h5A, 1'b1, 7'd0});
        vecs.push_back('{1'b0, 8'h33, 1'b0, 1'b0, 7'd0, 8'h5A, 1'b1, 7'd0});

        foreach (vecs[i]) begin
            step(vecs[i].en, vecs[i].din, vecs[i].clr, vecs[i].cfg_load, vecs[i].cfg_delay);
            chk($sformatf("vec%0d.data", i), int'(bus.data_out), int'(vecs[i].exp_data));
            chk($sformatf("vec%0d.valid", i), int'(bus.valid_out), int'(vecs[i].exp_valid));
            chk($sformatf("vec%0d.delay", i), int'(bus.delay_q), int'(vecs[i].exp_delay));
        end

        // Maximum delay across two pointer wraps.
        step(1'b0, '0, 1'b0, 1'b1, 7'(MAX_DELAY));
        chk("maxd.delay", int'(bus.delay_q), 127);
        chk_out("maxd.flushed", 0, 0);
        for (int k = 1; k <= 300; k++) begin
            step(1'b1, 8'(k - 1), 1'b0, 1'b0, '0);
            chk_out($sformatf("maxd.en%0d", k),
                    (k >= 128) ? ((k - 128) & 8'hFF) : 0, (k >= 128) ? 1 : 0);
        end

        // Gapped enable at D=5 with a ramp of data.
        step(1'b0, '0, 1'b0, 1'b1, 7'd5);
        n = 0;
        exp_d = 0;
        exp_v = 0;
        for (int c = 0; c < 120; c++) begin
            if ($urandom_range(0, 99) < 40) begin
                ramp = 8'(n * 3 + 7);
                if (n >= 5) begin
                    exp_d = ((n - 5) * 3 + 7) & 8'hFF;
                    exp_v = 1;
                end
                step(1'b1, ramp, 1'b0, 1'b0, '0);
                n++;
            end else begin
                step(1'b0, 8'hEE, 1'b0, 1'b0, '0);
            end
            chk_out($sformatf("gap.c%0d", c), exp_d, exp_v);
        end

        // Mid-stream clr with a same-cycle en at D=3.
        step(1'b0, '0, 1'b0, 1'b1, 7'd3);
        for (int k = 0; k < 10; k++) step(1'b1, 8'(8'h40 + k), 1'b0, 1'b0, '0);
        chk_out("clr.pre", 8'h46, 1);
        step(1'b1, 8'hEE, 1'b1, 1'b0, '0);
        chk_out("clr.flush", 0, 0);
        chk("clr.delay_kept", int'(bus.delay_q), 3);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 8'(8'h80 + k), 1'b0, 1'b0, '0);
            chk_out($sformatf("clr.prime%0d", k), 0, 0);
        end
        step(1'b1, 8'h83, 1'b0, 1'b0, '0);
        chk_out("clr.first", 8'h80, 1);

        // cfg_load 3 -> 8 together with clr and en.
        for (int k = 0; k < 6; k++) step(1'b1, 8'(8'h90 + k), 1'b0, 1'b0, '0);
        step(1'b1, 8'hEE, 1'b1, 1'b1, 7'd8);
        chk("ldclr.delay", int'(bus.delay_q), 8);
        chk_out("ldclr.flush", 0, 0);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 8'(8'hC0 + k), 1'b0, 1'b0, '0);
            chk_out($sformatf("ldclr.prime%0d", k), 0, 0);
        end
        step(1'b1, 8'hC8, 1'b0, 1'b0, '0);
        chk_out("ldclr.first", 8'hC0, 1);
        step(1'b1, 8'hC9, 1'b0, 1'b0, '0);
        chk_out("ldclr.second", 8'hC1, 1);

        // Asynchronous reset between clock edges.
        #2;
        rstn = 1'b0;
        #1;
        chk_out("areset", 0, 0);
        chk("areset.delay", int'(bus.delay_q), 20);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        step(1'b1, 8'h11, 1'b0, 1'b0, '0);
        chk_out("areset.after", 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ehgu_sr_mem_prog.md
Name: ehgu_sr_mem_prog

Overview:
- Runtime-programmable delay line for streaming samples, gated by an enable strobe.
- Delay storage sits in a dual-port RAM, not flops.
- Successor to the fixed-delay memory shift register. Adds:
  - a delay value loadable at run time;
  - a synchronous flush;
  - a fill counter that drives an output-valid qualifier;
  - zero output until the line is primed.

Parameters:
- WIDTH, 8, sample width in bits.
- MEM_DEPTH, 128, RAM depth in words. Must be a power of two, >= 4.
- DEF_DELAY, 20, delay applied out of reset. Range 0..MEM_DEPTH-1.
- AWIDTH, $clog2(MEM_DEPTH), localparam: address, delay and fill-counter width.

Ports:
- clk, input, 1, clock.
- rstn, input, 1, asynchronous active-low reset.
- en, input, 1, sample strobe. One sample is accepted per cycle with en=1.
- data_in, input, WIDTH, sample accepted when en=1.
- clr, input, 1, synchronous flush of line contents (pointers and fill count).
- cfg_load, input, 1, single-cycle pulse: load cfg_delay as the new delay.
- cfg_delay, input, AWIDTH, requested delay in en strobes (0..MEM_DEPTH-1).
- data_out, output, WIDTH, delayed sample.
- valid_out, output, 1, data_out holds a real delayed sample (line primed).
- delay_q, output, AWIDTH, currently active delay.

Behaviour:
- Reset (rstn low, asynchronous):
  - data_out=0, valid_out=0, delay_q=DEF_DELAY;
  - write pointer=0, fill counter=0.
  - RAM contents are don't-care.
- Transfer function: number accepted samples x[0], x[1], ... from the last reset/clr/cfg_load. On the cycle after the en cycle that accepts x[n]:
  - data_out = x[n-D] when n >= D, else 0;
  - valid_out = (n >= D);
  - D = delay_q.
- Outputs are registered and hold their value while en=0.
- D=0: data_out = x[n] one cycle after acceptance (pure register path, RAM bypassed). valid_out=1 from the first en.
- D >= 1: data is read from RAM. The read address is computed so that the registered RAM output aligns exactly with the rule above. The read and write addresses are never equal in the same cycle.
- Pointer wrap: write and read pointers increment modulo MEM_DEPTH on en; natural overflow of AWIDTH bits.
- Fill counter:
  - increments on en while fill < D;
  - saturates at D;
  - valid_out is asserted from the en that accepts sample x[D].
  - The counter never wraps.
- cfg_load:
  - delay_q <= cfg_delay, saturated to MEM_DEPTH-1 (only relevant if the ports are resized);
  - fill counter, pointers, data_out and valid_out are cleared as for clr.
  - An en in the same cycle is ignored; the sample is dropped.
- clr: clears pointers, fill count, data_out and valid_out; delay_q is kept. An en in the same cycle is ignored.
- Simultaneous clr and cfg_load: cfg_load semantics apply, so the new delay is loaded and the line is flushed.
- Priority: rstn > cfg_load > clr > en.
- Flushed data: stale RAM contents are never visible. data_out is forced to 0 until valid_out.
- Throughput: one sample per cycle with continuous en. There are no stall or back-pressure outputs.

Decomposition:
- Package ehgu_sr_pkg:
  - function for the minimum address width;
  - constant for the maximum legal delay (MEM_DEPTH-1), used by the RTL and the bench.
- Sub-module: existing ehgu_ram_dual_port (DEPTH=MEM_DEPTH, WIDTH=WIDTH, same clk on both ports, renable=en).
- Pointer/fill control is local logic; no further sub-module.

Test Plan:
- Reset, then 30 continuous en with data_in=1..30, DEF_DELAY=20:
  - data_out=0 and valid_out=0 after en 1..20;
  - after en 21 data_out=1, valid_out=1;
  - after en 30 data_out=10.
- cfg_load with cfg_delay=0, then en with data 0xA5, 0x5A → data_out=0xA5 one cycle after the first en, valid_out=1 immediately.
- cfg_delay=127 (MEM_DEPTH-1), stream 0..299 continuous:
  - valid_out rises after en 128;
  - data_out = n-127 thereafter, across two pointer wraps;
  - no read/write collision.
- en gapped randomly (en=1 on 40% of cycles), D=5, ramp data → data_out tracks x[n-5] per accepted sample and holds during en=0 gaps.
- Mid-stream clr while valid_out=1, D=3, with en in the same cycle:
  - outputs are 0 the next cycle and the sample is dropped;
  - the next 3 en give data_out=0 and valid_out=0;
  - the 4th en gives the first post-clr sample.
- Mid-stream cfg_load 3→8 with clr in the same cycle → delay_q=8 and the line is flushed. Also assert rstn low mid-stream → outputs 0 immediately (asynchronous) and delay_q returns to 20.
